// File: rtl/pe_traffic_endpoint.sv
// pe_traffic_endpoint
// Processing-element traffic endpoint for a NoC router local port.
//  - Generator: IDLE/GAP/SEND FSM injecting flits {dest, src, seq, tx_count[7:0]}
//    under credit-based flow control (CREDIT_INIT credits, one returned per ci).
//  - Sink: counts ejected flits and raises a sticky error on misrouted flits.
// Optional feature macro: PE_SEQ_CHECK_EN
//  When defined, a 16 x 4-bit expected-sequence table (indexed by source ID)
//  also flags out-of-order sequence numbers on the receive side.
module pe_traffic_endpoint #(
    parameter int CREDIT_INIT = 4,
    parameter int GAP         = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [3:0]  position,
    input  logic        enable,
    input  logic [19:0] datain,
    input  logic        in_valid,
    input  logic        ci,
    output logic [19:0] dataout,
    output logic        out_valid,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic        err
);

    localparam logic [3:0] CREDIT_MAX = 4'(CREDIT_INIT);
    localparam logic [7:0] GAP_LD     = 8'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_gap_cnt;
    logic [3:0]  r_credit;
    logic [3:0]  r_seq;
    logic [3:0]  r_dest;
    logic        r_dest_init;
    logic [19:0] r_dataout;
    logic        r_out_valid;
    logic [15:0] r_tx_count;
    logic [15:0] r_rx_count;
    logic        r_err;

    logic        w_send;
    logic [3:0]  w_credit_nxt;
    logic        w_seq_bad;
    logic        w_unused;

    // Next destination: step by one modulo 16, never addressing ourselves.
    function automatic logic [3:0] next_dest(input logic [3:0] cur, input logic [3:0] own);
        logic [3:0] n;
        n = cur + 4'd1;
        if (n == own) begin
            n = n + 4'd1;
        end else begin
            n = n;
        end
        return n;
    endfunction

    // A flit leaves only from SEND and only while a credit is held.
    assign w_send = (r_state == ST_SEND) && (r_credit != 4'd0);

    // Credit bookkeeping: send+return cancel, a lone return saturates at the buffer depth.
    always_comb begin
        w_credit_nxt = r_credit;
        case ({w_send, ci})
            2'b10: w_credit_nxt = r_credit - 4'd1;
            2'b01: begin
                if (r_credit < CREDIT_MAX) begin
                    w_credit_nxt = r_credit + 4'd1;
                end else begin
                    w_credit_nxt = r_credit;
                end
            end
            default: w_credit_nxt = r_credit;
        endcase
    end

    // Generator FSM with registered flit outputs, credit, sequence and destination state.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= 8'd0;
            r_credit    <= CREDIT_MAX;
            r_seq       <= 4'd0;
            r_dest      <= 4'd0;
            r_dest_init <= 1'b0;
            r_dataout   <= 20'd0;
            r_out_valid <= 1'b0;
            r_tx_count  <= 16'd0;
        end else begin
            r_out_valid <= 1'b0;
            r_credit    <= w_credit_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (GAP_LD == 8'd0) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= GAP_LD;
                    end
                end
                ST_GAP: begin
                    // The counter reaches 0 on the transition to SEND, so GAP
                    // idle cycles separate consecutive flits.
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= 8'd0;
                    end else if (r_gap_cnt <= 8'd1) begin
                        r_state   <= ST_SEND;
                        r_gap_cnt <= 8'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                ST_SEND: begin
                    if (w_send) begin
                        // An in-flight send completes even if enable just dropped.
                        r_out_valid <= 1'b1;
                        r_dataout   <= {r_dest, position, r_seq, r_tx_count[7:0]};
                        r_seq       <= r_seq + 4'd1;
                        r_tx_count  <= r_tx_count + 16'd1;
                        r_dest      <= next_dest(r_dest, position);
                        if (!enable) begin
                            r_state <= ST_IDLE;
                        end else if (GAP_LD == 8'd0) begin
                            r_state <= ST_SEND;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LD;
                        end
                    end else if (!enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gap_cnt <= 8'd0;
                end
            endcase
            // First edge after reset: position is stable, seed the destination.
            if (!r_dest_init) begin
                r_dest_init <= 1'b1;
                r_dest      <= position + 4'd1;
            end
        end
    end

`ifdef PE_SEQ_CHECK_EN
    logic [3:0] r_exp_seq [16];

    assign w_seq_bad = (r_exp_seq[datain[15:12]] != datain[11:8]);

    // Expected-sequence table: after each received flit expect its seq+1 from that source.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) begin
                r_exp_seq[i] <= 4'd0;
            end
        end else if (in_valid) begin
            r_exp_seq[datain[15:12]] <= datain[11:8] + 4'd1;
        end
    end
`else
    assign w_seq_bad = 1'b0;
`endif

    // Payload bits that the sink does not inspect.
    assign w_unused = ^datain[15:0];

    // Sink: count every ejected flit, latch a sticky error on a bad flit.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_rx_count <= 16'd0;
            r_err      <= 1'b0;
        end else if (in_valid) begin
            r_rx_count <= r_rx_count + 16'd1;
            if ((datain[19:16] != position) || w_seq_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign dataout   = r_dataout;
    assign out_valid = r_out_valid;
    assign tx_count  = r_tx_count;
    assign rx_count  = r_rx_count;
    assign err       = r_err;

endmodule

// File: doc/pe_traffic_endpoint.md
PE_TRAFFIC_ENDPOINT -- requirements
Module: pe_traffic_endpoint

Interface
REQ-001 Parameter: CREDIT_INIT, 4, router local-port input buffer depth; initial and maximum credit count (1..15).
REQ-002 Parameter: GAP, 8, idle cycles between generated flits (0..255).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: position  input  4  own node ID; stable while RST high.
REQ-006 Port: enable  input  1  traffic generation enable.
REQ-007 Port: datain  input  20  ejected flit from router local port.
REQ-008 Port: in_valid  input  1  datain valid; one flit per cycle, no backpressure.
REQ-009 Port: ci  input  1  credit return from router; one credit per cycle high.
REQ-010 Port: dataout  output  20  flit injected into router local port.
REQ-011 Port: out_valid  output  1  dataout valid, one cycle per flit.
REQ-012 Port: tx_count  output  16  flits sent, wraps at 65535->0.
REQ-013 Port: rx_count  output  16  flits received, wraps at 65535->0.
REQ-014 Port: err  output  1  sticky receive-error flag.

Function
REQ-015 Flit format SHALL be [19:16] dest, [15:12] src = position, [11:8] seq, [7:0] tx_count[7:0] at send time.
REQ-016 Generator FSM SHALL have states IDLE, GAP, SEND.
REQ-017 IDLE: go to GAP when enable=1; any state returns to IDLE next cycle when enable=0 (an in-flight send cycle completes first).
REQ-018 GAP: gap counter loads GAP on entry, decrements each cycle; at 0 go to SEND (GAP=0 goes straight to SEND).
REQ-019 SEND with credit>0: dataout/out_valid registered high for exactly one cycle, credit decrements, tx_count and seq increment, dest advances, go to GAP.
REQ-020 SEND with credit=0: out_valid=0, hold in SEND, send on first cycle credit>0.
REQ-021 Credit counter: 4 bits; send and ci in the same cycle leave it unchanged; ci alone increments, saturating at CREDIT_INIT (excess ci ignored).
REQ-022 dest SHALL start at (position+1) mod 16, advance by 1 mod 16 per sent flit, skipping position.
REQ-023 seq SHALL be 4 bits, wrapping 15->0.
REQ-024 out_valid SHALL never be high when credit=0 at the start of that cycle.
REQ-025 Sink: each in_valid cycle increments rx_count by one, independent of generator state.
REQ-026 Sink: in_valid with datain[19:16] != position SHALL set err next cycle; err stays high until reset.
REQ-027 dataout SHALL hold the last sent flit while out_valid=0.

Reset
REQ-028 RST low SHALL immediately force: dataout=0, out_valid=0, tx_count=0, rx_count=0, err=0, FSM=IDLE, credit=CREDIT_INIT, seq=0, gap counter=0, sequence table (if present) all 0.
REQ-029 dest SHALL load (position+1) mod 16 on the first clock edge after RST deasserts.
REQ-030 Reset mid-send SHALL drop the flit; no partial out_valid is produced.

Configuration
REQ-031 Macro PE_SEQ_CHECK_EN defined: 16-entry x 4-bit expected-sequence table indexed by datain[15:12]; a received seq != expected sets err; the entry is then set to received seq+1 (mod 16).
REQ-032 PE_SEQ_CHECK_EN undefined: no table; err driven by the destination check only.

Verification
REQ-033 Reset, position=5, GAP=2, enable=1, ci tied 0 -> flits to dest 6,7,8,9 (seq 0..3), each 3 cycles apart, then out_valid stays 0.
REQ-034 After REQ-033 pulse ci once -> exactly one flit, dest 10 seq 4; credit back to 0.
REQ-035 position=15, ci returned every send -> dest sequence 0,1,...,14,0 (15 never used), tx_count increments per flit.
REQ-036 Send and ci in same cycle with credit=1 -> credit stays 1, next send not stalled; 3 extra ci pulses at credit=CREDIT_INIT -> credit remains 4.
REQ-037 position=3, in_valid with dest 3 then dest 4 -> rx_count=2, err=1 from cycle after second flit; RST low -> err=0 immediately.
REQ-038 PE_SEQ_CHECK_EN defined: src 2 flits seq 0,1,3 -> err set after seq 3; undefined -> err stays 0.
